// File: rtl/hash_des_pkg.sv
// rtl/hash_des_pkg.sv - DES S-box tables, round function and FSM types for hash_des_stream
// A round folds one message byte into eight 4-bit lanes through the eight DES S-boxes.
package hash_des_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, ABSORB, FINAL, DONE} state_t;

   localparam logic [31:0] DEFAULT_IV = 32'h3406_2F1B;

   // Standard DES S1..S8, each row-major: entry index = row*16 + col.
   localparam int unsigned SBOX_TAB [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   // Row comes from the outer bits x[5],x[0]; column from x[4:1].
   function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [5:0] x6);
      logic [5:0] addr;
      addr = {x6[5], x6[0], x6[4:1]};
      return SBOX_TAB[idx][addr][3:0];
   endfunction

   function automatic logic [31:0] des_round(input logic [31:0] h, input logic [7:0] m);
      logic [5:0]  x;
      logic [31:0] hp;
      x  = {m[7:6] ^ m[1:0], m[5:2]};
      hp = '0;
      for (int i = 0; i < 8; i++) begin
         hp[4*i +: 4] = h[4*((i+1)%8) +: 4] ^ sbox(3'(i), x);
      end
      return {hp[29:0], hp[31:30]};
   endfunction

endpackage

// File: rtl/hash_des_stream_round_core.sv
// rtl/hash_des_stream_round_core.sv - combinational single-round datapath (hash_des_round_core)
// Kept as its own module so the top shares one round engine between message and length bytes.
module hash_des_round_core
   import hash_des_pkg::*;
(
   input  logic [31:0] h_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] h_o
);

   assign h_o = des_round(h_i, byte_i);

endmodule

// File: rtl/hash_des_stream.sv
// rtl/hash_des_stream.sv - multi-byte-beat DES S-box hash with length finalisation
// Optional length-mismatch flag via HASH_DES_LEN_CHECK_EN (adds the len_err port).
module hash_des_stream
   import hash_des_pkg::*;
#(
   parameter int          MSG_BYTES = 1,
   parameter int          ROUNDS    = 1,
   parameter int          CNT_W     = 64,
   parameter logic [31:0] IV        = DEFAULT_IV
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [CNT_W-1:0]       counter,
   input  logic                   M_valid,
   output logic                   M_ready,
   input  logic [8*MSG_BYTES-1:0] message,
   output logic [31:0]            digest_out,
   output logic                   hash_ready
`ifdef HASH_DES_LEN_CHECK_EN
   ,output logic                  len_err
`endif
);

   localparam int LEN_BYTES = CNT_W / 8;
   localparam int MAX_BYTES = (LEN_BYTES > MSG_BYTES) ? LEN_BYTES : MSG_BYTES;
   localparam int BL_W      = $clog2(MAX_BYTES + 1);
   localparam int RC_W      = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

   state_t                 state_q;
   logic [31:0]            h_q;
   logic [31:0]            digest_q;
   logic [CNT_W-1:0]       rem_q;
   logic [CNT_W-1:0]       len_q;
   logic [8*MSG_BYTES-1:0] beat_q;
   logic [BL_W-1:0]        bytes_q;
   logic [RC_W-1:0]        round_q;
   logic                   m_ready_q;
   logic                   hash_ready_q;

   logic [7:0]             cur_byte;
   logic [31:0]            h_next;
   logic                   round_last;
   logic [BL_W-1:0]        take_n;

   assign cur_byte   = (state_q == FINAL) ? len_q[7:0] : beat_q[7:0];
   assign round_last = (round_q == RC_W'(ROUNDS - 1));
   // Only the bytes still owed by the declared length are absorbed from a beat.
   assign take_n     = (rem_q < CNT_W'(MSG_BYTES)) ? BL_W'(rem_q) : BL_W'(MSG_BYTES);

   hash_des_round_core u_core (
      .h_i    (h_q),
      .byte_i (cur_byte),
      .h_o    (h_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         h_q          <= IV;
         digest_q     <= '0;
         rem_q        <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         bytes_q      <= '0;
         round_q      <= '0;
         m_ready_q    <= 1'b0;
         hash_ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  len_q   <= counter;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               h_q          <= IV;
               rem_q        <= len_q;
               round_q      <= '0;
               hash_ready_q <= 1'b0;
               if (len_q == '0) begin
                  bytes_q <= BL_W'(LEN_BYTES);
                  state_q <= FINAL;
               end else begin
                  m_ready_q <= 1'b1;
                  state_q   <= ABSORB;
               end
            end
            ABSORB: begin
               if (m_ready_q) begin
                  if (M_valid) begin
                     beat_q    <= message;
                     bytes_q   <= take_n;
                     m_ready_q <= 1'b0;
                  end
               end else begin
                  h_q <= h_next;
                  if (round_last) begin
                     round_q <= '0;
                     beat_q  <= beat_q >> 8;
                     bytes_q <= bytes_q - 1'b1;
                     rem_q   <= rem_q - 1'b1;
                     if (bytes_q == BL_W'(1)) begin
                        if (rem_q == CNT_W'(1)) begin
                           bytes_q <= BL_W'(LEN_BYTES);
                           state_q <= FINAL;
                        end else begin
                           m_ready_q <= 1'b1;
                        end
                     end
                  end else begin
                     round_q <= round_q + 1'b1;
                  end
               end
            end
            FINAL: begin
               if (bytes_q == '0) begin
                  digest_q     <= h_q;
                  hash_ready_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  h_q <= h_next;
                  if (round_last) begin
                     round_q <= '0;
                     len_q   <= len_q >> 8;
                     bytes_q <= bytes_q - 1'b1;
                  end else begin
                     round_q <= round_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign M_ready    = m_ready_q;
   assign digest_out = digest_q;
   assign hash_ready = hash_ready_q;

`ifdef HASH_DES_LEN_CHECK_EN
   logic len_err_q;
   logic start_ok;

   assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));

   // Extra data after DONE or a restart attempt mid-message both flag a length mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_err_q <= 1'b0;
      end else if (start_ok) begin
         len_err_q <= 1'b0;
      end else if (((state_q == DONE) & M_valid) | ((state_q == ABSORB) & start)) begin
         len_err_q <= 1'b1;
      end
   end

   assign len_err = len_err_q;
`endif

endmodule

// File: tb/tb_hash_des_stream.sv
// tb/tb_hash_des_stream.sv - directed scoreboard bench over three hash_des_stream configurations
module tb_hash_des_stream;

   localparam logic [31:0] IV_REF = 32'h3406_2F1B;

   localparam int SB [8][4][16] = '{
      '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
        '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
        '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
        '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
      '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
        '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
        '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
        '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
      '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
        '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
        '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
        '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
      '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
        '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
        '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
        '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
      '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
        '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
        '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
        '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
      '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
        '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
        '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
        '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
      '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
        '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
        '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
        '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
      '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
        '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
        '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
        '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_s [3];
   logic [63:0] cnt_s   [3];
   logic        mval_s  [3];
   logic        mrdy_s  [3];
   logic [31:0] dig_s   [3];
   logic        hrdy_s  [3];
   logic [7:0]  msg0;
   logic [31:0] msg1;
   logic [15:0] msg2;
`ifdef HASH_DES_LEN_CHECK_EN
   logic        lerr_s  [3];
`endif

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   hash_des_stream #(.MSG_BYTES(1), .ROUNDS(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .counter(cnt_s[0]),
      .M_valid(mval_s[0]), .M_ready(mrdy_s[0]), .message(msg0),
      .digest_out(dig_s[0]), .hash_ready(hrdy_s[0])
`ifdef HASH_DES_LEN_CHECK_EN
      , .len_err(lerr_s[0])
`endif
   );

   hash_des_stream #(.MSG_BYTES(4), .ROUNDS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .counter(cnt_s[1]),
      .M_valid(mval_s[1]), .M_ready(mrdy_s[1]), .message(msg1),
      .digest_out(dig_s[1]), .hash_ready(hrdy_s[1])
`ifdef HASH_DES_LEN_CHECK_EN
      , .len_err(lerr_s[1])
`endif
   );

   hash_des_stream #(.MSG_BYTES(2), .ROUNDS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .counter(cnt_s[2]),
      .M_valid(mval_s[2]), .M_ready(mrdy_s[2]), .message(msg2),
      .digest_out(dig_s[2]), .hash_ready(hrdy_s[2])
`ifdef HASH_DES_LEN_CHECK_EN
      , .len_err(lerr_s[2])
`endif
   );

   function automatic logic [31:0] ref_round(input logic [31:0] h, input logic [7:0] m);
      logic [5:0]  x;
      logic [1:0]  row;
      logic [3:0]  col;
      logic [31:0] t;
      logic [3:0]  s;
      x   = {m[7:6] ^ m[1:0], m[5:2]};
      row = {x[5], x[0]};
      col = x[4:1];
      t   = '0;
      for (int i = 0; i < 8; i++) begin
         s = SB[i][row][col][3:0];
         t[4*i +: 4] = h[4*((i+1)%8) +: 4] ^ s;
      end
      return (t << 2) | (t >> 30);
   endfunction

   function automatic logic [31:0] model(input logic [7:0] m [$], input int rounds);
      logic [31:0] h;
      logic [63:0] len;
      h   = IV_REF;
      len = 64'(m.size());
      foreach (m[j]) for (int r = 0; r < rounds; r++) h = ref_round(h, m[j]);
      for (int j = 0; j < 8; j++) for (int r = 0; r < rounds; r++) h = ref_round(h, len[8*j +: 8]);
      return h;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic v, input logic [31:0] d);
      mval_s[k] = v;
      case (k)
         0:       msg0 = d[7:0];
         1:       msg1 = d;
         default: msg2 = d[15:0];
      endcase
   endtask

   task automatic pulse_start(input int k, input logic [63:0] len);
      @(negedge clk);
      start_s[k] = 1'b1;
      cnt_s[k]   = len;
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [31:0] d);
      int t;
      t = 0;
      drive(k, 1'b1, d);
      while (!mrdy_s[k] && t < 200) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("beat_ready_dut%0d", k), 64'(mrdy_s[k]), 64'd1);
      @(negedge clk);
      drive(k, 1'b0, 32'h0);
   endtask

   task automatic wait_done(input int k, input string tag, output int cyc);
      logic [31:0] e;
      cyc = 0;
      while (!hrdy_s[k] && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_hash_ready"}, 64'(hrdy_s[k]), 64'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_digest"}, 64'(dig_s[k]), 64'(e));
   endtask

   initial begin
      logic [7:0]  bq [$];
      logic [31:0] last_exp;
      logic [15:0] beats [3];
      int          cyc;
      int          t;
      int          low;

      for (int k = 0; k < 3; k++) begin
         start_s[k] = 1'b0;
         cnt_s[k]   = '0;
         mval_s[k]  = 1'b0;
      end
      msg0 = '0;
      msg1 = '0;
      msg2 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_mready_dut%0d", k), 64'(mrdy_s[k]), 64'd0);
         check($sformatf("reset_hready_dut%0d", k), 64'(hrdy_s[k]), 64'd0);
         check($sformatf("reset_digest_dut%0d", k), 64'(dig_s[k]), 64'd0);
      end

      // Empty message: LOAD + 8 length rounds + digest write
      bq = {};
      last_exp = model(bq, 1);
      exp_q.push_back(last_exp);
      pulse_start(0, 64'd0);
      wait_done(0, "empty", cyc);
      check("empty_latency", 64'(cyc), 64'd10);

      // Beats offered in DONE are never accepted and leave the digest alone
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 32'h55);
         @(negedge clk);
         check("done_no_accept", 64'(mrdy_s[0]), 64'd0);
      end
`ifdef HASH_DES_LEN_CHECK_EN
      check("len_err_extra_beat", 64'(lerr_s[0]), 64'd1);
`endif
      drive(0, 1'b0, 32'h0);
      check("done_digest_held", 64'(dig_s[0]), 64'(last_exp));

      // "A" on the byte-wide and the word-wide instance
      bq = '{8'h41};
      exp_q.push_back(model(bq, 1));
      pulse_start(0, 64'd1);
`ifdef HASH_DES_LEN_CHECK_EN
      check("len_err_cleared", 64'(lerr_s[0]), 64'd0);
`endif
      send(0, 32'h41);
      wait_done(0, "A_mb1", cyc);
      check("A_mb1_latency", 64'(cyc), 64'd10);

      exp_q.push_back(model(bq, 1));
      pulse_start(1, 64'd1);
      send(1, 32'h5A3C_9641);
      wait_done(1, "A_mb4", cyc);
      check("A_mb4_latency", 64'(cyc), 64'd10);

      // Upper bytes beyond the declared length are ignored
      bq = '{8'h41, 8'h42};
      exp_q.push_back(model(bq, 1));
      pulse_start(1, 64'd2);
      send(1, 32'hDEAD_4241);
      wait_done(1, "AB_mb4", cyc);

      // Two-beat message on the word instance, with an ignored start mid-ABSORB
      bq = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      exp_q.push_back(model(bq, 1));
      pulse_start(1, 64'd5);
      send(1, 32'h4C4C_4548);
      pulse_start(1, 64'd0);
`ifdef HASH_DES_LEN_CHECK_EN
      check("len_err_trunc", 64'(lerr_s[1]), 64'd1);
`endif
      send(1, 32'hA5A5_A54F);
      wait_done(1, "hello_mb4", cyc);
      check("hello_tail_latency", 64'(cyc), 64'd10);

      // Backpressure: M_valid held high across three 2-byte beats, 2 rounds per byte
      bq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      exp_q.push_back(model(bq, 2));
      beats = '{16'h4241, 16'h4443, 16'h4645};
      pulse_start(2, 64'd6);
      drive(2, 1'b1, 32'(beats[0]));
      for (int b = 0; b < 3; b++) begin
         t = 0;
         while (!mrdy_s[2] && t < 100) begin
            @(negedge clk);
            t++;
         end
         check($sformatf("bp_ready_beat%0d", b), 64'(mrdy_s[2]), 64'd1);
         @(negedge clk);
         if (b < 2) begin
            drive(2, 1'b1, 32'(beats[b+1]));
            low = 0;
            while (!mrdy_s[2] && low < 100) begin
               low++;
               @(negedge clk);
            end
            check($sformatf("bp_low_cycles_beat%0d", b), 64'(low), 64'd4);
         end else begin
            drive(2, 1'b0, 32'h0);
         end
      end
      wait_done(2, "bp_mb2_r2", cyc);
      check("bp_tail_latency", 64'(cyc), 64'd21);

      // Asynchronous reset while waiting for the second beat
      pulse_start(0, 64'd2);
      send(0, 32'h41);
      t = 0;
      while (!mrdy_s[0] && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("pre_reset_waiting", 64'(mrdy_s[0]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mready", 64'(mrdy_s[0]), 64'd0);
      check("async_rst_hready", 64'(hrdy_s[0]), 64'd0);
      check("async_rst_digest0", 64'(dig_s[0]), 64'd0);
      check("async_rst_digest2", 64'(dig_s[2]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      bq = '{8'h41, 8'h42};
      exp_q.push_back(model(bq, 1));
      pulse_start(0, 64'd2);
      send(0, 32'h41);
      send(0, 32'h42);
      wait_done(0, "AB_after_reset", cyc);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (errors=%0d of %0d checks)", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
